// File: rtl/gaussian3x3_stream_if.sv
// gaussian3x3_stream_if: valid/ready pixel stream with producer and consumer views
interface gaussian3x3_stream_if #(parameter int W = 12);
  logic [W-1:0] pixel;
  logic valid;
  logic ready;
  modport master (output pixel, valid, input ready);
  modport slave (input pixel, valid, output ready);
endinterface

// File: rtl/gaussian3x3_stream.sv
// gaussian3x3_stream: streaming 3x3 [1 2 1;2 4 2;1 2 1]/16 blur, valid-region output, one-deep output register
module gaussian3x3_stream #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IMG_ROWS = 20,
  parameter int IMG_COLS = 20
) (
  input logic clk,
  input logic reset,
  gaussian3x3_stream_if.slave up,
  gaussian3x3_stream_if.master dn
);
  localparam int W = PIXEL_BIT_WIDTH;
  localparam int XW = $clog2(IMG_COLS);
  localparam int YW = $clog2(IMG_ROWS);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [W-1:0] lb0 [IMG_COLS];
  logic [W-1:0] lb1 [IMG_COLS];
  // left two window columns; the right column is read live from the line buffers and input
  logic [W-1:0] w [3][2];
  logic [W-1:0] col [3];
  logic [W+3:0] sum, rnd;
  logic acc, done, x_last;
  assign up.ready = ~dn.valid | dn.ready;
  assign acc = up.valid & up.ready;
  assign x_last = x == XW'(IMG_COLS - 1);
  assign done = acc && x >= XW'(2) && y >= YW'(2);
  always_comb begin
    col[0] = lb1[x];
    col[1] = lb0[x];
    col[2] = up.pixel;
    sum = (W+4)'(w[0][0]) + (W+4)'(col[0]) + (W+4)'(w[2][0]) + (W+4)'(col[2])
        + (((W+4)'(w[0][1]) + (W+4)'(w[1][0]) + (W+4)'(col[1]) + (W+4)'(w[2][1])) << 1)
        + ((W+4)'(w[1][1]) << 2);
    rnd = sum + (W+4)'(8);
  end
  always_ff @(posedge clk)
    if (acc) begin
      lb1[x] <= lb0[x];
      lb0[x] <= up.pixel;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x <= '0;
      y <= '0;
      for (int r = 0; r < 3; r++) begin
        w[r][0] <= '0;
        w[r][1] <= '0;
      end
      dn.valid <= 1'b0;
      dn.pixel <= '0;
    end else begin
      if (acc) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= (y == YW'(IMG_ROWS - 1)) ? '0 : y + 1'b1;
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= col[r];
        end
      end
      if (done) begin
        dn.pixel <= rnd[W+3:4];
        dn.valid <= 1'b1;
      end else if (dn.valid & dn.ready) dn.valid <= 1'b0;
    end
endmodule

// File: tb/tb_gaussian3x3_stream.sv
// tb_gaussian3x3_stream: directed-vector bench for the 20x20 Gaussian blur stream
module tb_gaussian3x3_stream;
  logic clk, reset;
  gaussian3x3_stream_if #(.W(12)) up_if ();
  gaussian3x3_stream_if #(.W(12)) dn_if ();
  gaussian3x3_stream #(.PIXEL_BIT_WIDTH(12), .IMG_ROWS(20), .IMG_COLS(20)) dut (
    .clk(clk), .reset(reset), .up(up_if), .dn(dn_if));

  int pass_cnt = 0, total = 0, n_acc = 0, first_acc = -1;
  int ec, ee, ek;
  logic [11:0] q [$];

  always #5 clk = ~clk;
  always @(posedge clk) if (up_if.valid && up_if.ready) n_acc <= n_acc + 1;
  always @(posedge clk) if (dn_if.valid && dn_if.ready) q.push_back(dn_if.pixel);

  function automatic logic [11:0] pix(int mode, int v, int y, int x);
    return mode == 0 ? 12'(v) : mode == 1 ? 12'(x) : (y == 5 && x == 5) ? 12'(v) : 12'd0;
  endfunction

  function automatic int exp_val(int mode, int v, int i);
    int j = i % 324;
    int cy = j / 18 + 1, cx = j % 18 + 1;
    int dy = cy > 5 ? cy - 5 : 5 - cy;
    int dx = cx > 5 ? cx - 5 : 5 - cx;
    if (mode == 0) return v;
    if (mode == 1) return cx;
    return (dy == 0 && dx == 0) ? ec : (dy + dx == 1) ? ee : (dy == 1 && dx == 1) ? ek : 0;
  endfunction

  function automatic int first_bad(int mode, int v);
    for (int i = 0; i < q.size(); i++) if (int'(q[i]) != exp_val(mode, v, i)) return i;
    return -1;
  endfunction

  task automatic run_frame(input int mode, input int v, input int npix, input bit stall);
    bit done = 0;
    int base = n_acc;
    q.delete();
    first_acc = -1;
    fork
      begin
        for (int i = 0; i < npix; i++) begin
          int tgt, cnt;
          while (stall && $urandom_range(0, 2) == 0) begin
            up_if.valid = 0;
            @(negedge clk);
          end
          up_if.valid = 1;
          up_if.pixel = pix(mode, v, (i / 20) % 20, i % 20);
          tgt = n_acc + 1;
          cnt = 0;
          while (n_acc < tgt && cnt < 200) begin
            @(negedge clk);
            cnt++;
          end
          if (n_acc < tgt) begin
            total++;
            $display("FAIL accept_timeout pixel %0d got no accept want accept", i);
            break;
          end
        end
        up_if.valid = 0;
        done = 1;
      end
      begin
        int cyc = 0;
        bit ps = 0;
        logic [11:0] pp = 0;
        while (!(done && !dn_if.valid) && cyc < npix * 30) begin
          @(negedge clk);
          cyc++;
          if (first_acc < 0 && dn_if.valid) first_acc = n_acc - base;
          if (stall) begin
            if (ps) begin
              total++;
              if (dn_if.valid !== 1'b1 || dn_if.pixel !== pp)
                $display("FAIL hold got v=%0b p=%0d want v=1 p=%0d", dn_if.valid, dn_if.pixel, pp);
              else pass_cnt++;
            end
            if (dn_if.valid && !dn_if.ready) begin
              total++;
              if (up_if.ready !== 1'b0) $display("FAIL in_ready_stall got %0b want 0", up_if.ready);
              else pass_cnt++;
            end
          end
          dn_if.ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          ps = dn_if.valid && !dn_if.ready;
          pp = dn_if.pixel;
        end
        if (!(done && !dn_if.valid)) begin
          total++;
          $display("FAIL drain_timeout got busy want idle");
        end
        dn_if.ready = 1;
      end
    join
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (dn_if.valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", dn_if.valid); else pass_cnt++;
    total++;
    if (dn_if.pixel !== 12'd0) $display("FAIL reset_pixel_out got %0d want 0", dn_if.pixel); else pass_cnt++;
    total++;
    if (up_if.ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", up_if.ready); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_constant;
    int b;
    run_frame(0, 100, 400, 0);
    total++;
    if (q.size() !== 324) $display("FAIL const_count got %0d want 324", q.size()); else pass_cnt++;
    b = first_bad(0, 100);
    total++;
    if (b != -1) $display("FAIL const_seq idx %0d got %0d want 100", b, q[b]); else pass_cnt++;
    total++;
    if (first_acc !== 43) $display("FAIL const_latency got %0d want 43", first_acc); else pass_cnt++;
  endtask

  task automatic test_ramp;
    int b;
    run_frame(1, 0, 400, 0);
    total++;
    if (q.size() !== 324) $display("FAIL ramp_count got %0d want 324", q.size()); else pass_cnt++;
    b = first_bad(1, 0);
    total++;
    if (b != -1) $display("FAIL ramp_seq idx %0d got %0d want %0d", b, q[b], exp_val(1, 0, b)); else pass_cnt++;
    total++;
    if (q[0] !== 12'd1 || q[17] !== 12'd18) $display("FAIL ramp_ends got %0d,%0d want 1,18", q[0], q[17]); else pass_cnt++;
  endtask

  task automatic test_impulse;
    int b;
    ec = 40; ee = 20; ek = 10;
    run_frame(2, 160, 400, 0);
    total++;
    if (q.size() !== 324) $display("FAIL imp_count got %0d want 324", q.size()); else pass_cnt++;
    b = first_bad(2, 160);
    total++;
    if (b != -1) $display("FAIL imp_seq idx %0d got %0d want %0d", b, q[b], exp_val(2, 160, b)); else pass_cnt++;
    total++;
    if (q[76] !== 12'd40) $display("FAIL imp_centre got %0d want 40", q[76]); else pass_cnt++;
    total++;
    if (q[58] !== 12'd20 || q[75] !== 12'd20) $display("FAIL imp_edge got %0d,%0d want 20", q[58], q[75]); else pass_cnt++;
    total++;
    if (q[57] !== 12'd10 || q[95] !== 12'd10) $display("FAIL imp_corner got %0d,%0d want 10", q[57], q[95]); else pass_cnt++;
  endtask

  task automatic test_rounding;
    int b;
    ec = 1; ee = 0; ek = 0;
    run_frame(2, 2, 400, 0);
    total++;
    if (q[76] !== 12'd1) $display("FAIL round_half_up got %0d want 1", q[76]); else pass_cnt++;
    b = first_bad(2, 2);
    total++;
    if (b != -1 || q.size() !== 324) $display("FAIL round2_seq idx %0d size %0d want -1 324", b, q.size()); else pass_cnt++;
    ec = 0;
    run_frame(2, 1, 400, 0);
    total++;
    if (q[76] !== 12'd0) $display("FAIL round_below_half got %0d want 0", q[76]); else pass_cnt++;
  endtask

  task automatic test_full_scale;
    int b;
    run_frame(0, 4095, 400, 0);
    total++;
    if (q.size() !== 324) $display("FAIL full_count got %0d want 324", q.size()); else pass_cnt++;
    b = first_bad(0, 4095);
    total++;
    if (b != -1) $display("FAIL full_seq idx %0d got %0d want 4095", b, q[b]); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int b;
    run_frame(0, 100, 400, 1);
    total++;
    if (q.size() !== 324) $display("FAIL bp_const_count got %0d want 324", q.size()); else pass_cnt++;
    b = first_bad(0, 100);
    total++;
    if (b != -1) $display("FAIL bp_const_seq idx %0d got %0d want 100", b, q[b]); else pass_cnt++;
    run_frame(1, 0, 400, 1);
    total++;
    if (q.size() !== 324) $display("FAIL bp_ramp_count got %0d want 324", q.size()); else pass_cnt++;
    b = first_bad(1, 0);
    total++;
    if (b != -1) $display("FAIL bp_ramp_seq idx %0d got %0d want %0d", b, q[b], exp_val(1, 0, b)); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    int b, tgt, cnt = 0;
    run_frame(0, 50, 7 * 20 + 3, 0);
    dn_if.ready = 0;
    up_if.valid = 1;
    up_if.pixel = 12'd50;
    tgt = n_acc + 1;
    while (n_acc < tgt && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    up_if.valid = 0;
    total++;
    if (dn_if.valid !== 1'b1) $display("FAIL mid_held got %0b want 1", dn_if.valid); else pass_cnt++;
    #2 reset = 0;
    #1;
    total++;
    if (dn_if.valid !== 1'b0 || dn_if.pixel !== 12'd0)
      $display("FAIL async_reset got v=%0b p=%0d want v=0 p=0", dn_if.valid, dn_if.pixel);
    else pass_cnt++;
    total++;
    if (up_if.ready !== 1'b1) $display("FAIL async_in_ready got %0b want 1", up_if.ready); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1;
    dn_if.ready = 1;
    run_frame(1, 0, 400, 0);
    total++;
    if (q.size() !== 324) $display("FAIL post_reset_count got %0d want 324", q.size()); else pass_cnt++;
    b = first_bad(1, 0);
    total++;
    if (b != -1) $display("FAIL post_reset_seq idx %0d got %0d want %0d", b, q[b], exp_val(1, 0, b)); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int b;
    run_frame(1, 0, 800, 0);
    total++;
    if (q.size() !== 648) $display("FAIL b2b_count got %0d want 648", q.size()); else pass_cnt++;
    b = first_bad(1, 0);
    total++;
    if (b != -1) $display("FAIL b2b_seq idx %0d got %0d want %0d", b, q[b], exp_val(1, 0, b)); else pass_cnt++;
  endtask

  initial begin
    clk = 0;
    reset = 0;
    up_if.valid = 0;
    up_if.pixel = 0;
    dn_if.ready = 1;
    test_reset;
    test_constant;
    test_ramp;
    test_impulse;
    test_rounding;
    test_full_scale;
    test_backpressure;
    test_reset_mid_frame;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/gaussian3x3_stream.md
Name: gaussian3x3_stream

Overview:
- Streaming 3x3 Gaussian blur stage that sits directly downstream of the crop stage. It consumes the cropped raster through a valid/ready handshake.
- Input is an IMG_ROWS x IMG_COLS frame in row-major order, one pixel per accepted beat.
- Output is the "valid" convolution: a (IMG_ROWS-2) x (IMG_COLS-2) raster, row-major, with no border padding.
- Kernel is [1 2 1; 2 4 2; 1 2 1]/16 with round-half-up.

Parameters:
- PIXEL_BIT_WIDTH, 12, pixel width for input and output.
- IMG_ROWS, 20, rows per input frame; must match the upstream crop OUT_ROWS; minimum 3.
- IMG_COLS, 20, columns per input frame; must match the upstream crop OUT_COLS; minimum 3.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserts when 0).
- pixel_in  input  PIXEL_BIT_WIDTH  input pixel.
- in_valid  input  1  pixel_in is valid.
- in_ready  output  1  block accepts pixel_in this cycle.
- pixel_out  output  PIXEL_BIT_WIDTH  filtered pixel.
- out_valid  output  1  pixel_out is valid.
- out_ready  input  1  downstream accepts pixel_out this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, pixel_out=0, column counter x=0, row counter y=0, window registers=0.
  - Line-buffer RAM contents are not reset.
  - in_ready is combinational and equals 1 while out_valid=0.
  - Reset mid-frame discards the partial frame and any held output; the next accepted pixel is treated as (0,0).
- Handshake:
  - in_ready = ~out_valid | out_ready (one-deep output register).
  - Accept occurs when in_valid & in_ready.
  - Output is transferred when out_valid & out_ready.
  - An output must hold pixel_out stable while out_valid=1 and out_ready=0.
  - No input is accepted while an output is stalled, including pixels that would not produce an output.
- Counters:
  - x and y advance only on accept.
  - x wraps IMG_COLS-1 -> 0 and then increments y.
  - y wraps IMG_ROWS-1 -> 0. Frames run back-to-back with no gap required.
- Storage:
  - Two line buffers of IMG_COLS entries: LB0 holds row y-1, LB1 holds row y-2.
  - On accept at column x: LB1[x] <= LB0[x], LB0[x] <= pixel_in.
  - The 3x3 window shifts left by one column. The new right column is (LB1[x], LB0[x], pixel_in), read before the write.
- Output generation:
  - An accepted pixel at (y,x) with y>=2 and x>=2 completes the window centred on input (y-1,x-1).
  - On that accept cycle, pixel_out <= result and out_valid <= 1 at the next edge. Latency is 1 cycle from the completing accept.
  - Accepts with y<2 or x<2 update state only.
  - If an output transfers and there is no new completing accept in the same cycle, out_valid drops to 0.
  - Simultaneous transfer and new completing accept: out_valid stays 1 and pixel_out takes the new value.
- Arithmetic:
  - Unsigned sum = c + 2*e + 4*m, where c is the sum of the 4 corners, e is the sum of the 4 edges, and m is the centre.
  - Sum width is PIXEL_BIT_WIDTH+4, with no overflow possible.
  - result = (sum + 8) >> 4, truncated to PIXEL_BIT_WIDTH. Saturation is never needed, since max input gives max output.
- Window contents from a previous row's tail, or from a previous frame, never reach the output because of the x>=2 / y>=2 gating.
- Output count is (IMG_ROWS-2)*(IMG_COLS-2) per frame, in row-major order.

Test Plan:
- Constant frame: 20x20 of value 100, out_ready=1 -> exactly 324 outputs, all 100; first out_valid one cycle after input (2,2) is accepted.
- Horizontal ramp: pixel=x -> each output row is 1,2,...,18.
- Impulse: 160 at input (5,5), all else 0 ->
  - 40 at output centred on (5,5);
  - 20 at its 4 edge neighbours;
  - 10 at its 4 corners;
  - 0 elsewhere.
  - Rounding check on the same position: value 2 -> 1, value 1 -> 0.
- Full scale: all pixels 4095 -> all outputs 4095 (no wrap).
- Backpressure: random in_valid and out_ready toggling on the constant and ramp frames ->
  - sequences identical to the no-stall runs;
  - pixel_out stable while stalled;
  - in_ready=0 while out_valid=1 and out_ready=0.
- Reset mid-frame at input row 7: assert reset=0 for 2 cycles ->
  - out_valid=0 immediately (async);
  - next frame yields exactly 324 correct outputs;
  - two back-to-back frames yield 648 outputs.
